gif_frame_sequencer: RTL

GIF_FRAME_SEQUENCER -- requirements
Module: gif_frame_sequencer

---
 rtl/gif_frame_sequencer.sv | 69 ++++++
 1 files changed

// File: rtl/gif_frame_sequencer.sv
// gif_frame_sequencer: steps a panel driver through GIF frames stored back-to-back; GIF_LOOP_EN selects looping vs stop-at-last-frame.
module gif_frame_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_WORDS = 2048,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              pause,
  input  logic [7:0]        hold,
  input  logic              frame_done,
  output logic              panel_init,
  output logic [ADDR_W-1:0] frame_base,
  output logic [7:0]        frame_idx,
  output logic              busy,
  output logic              anim_done
);
  typedef enum logic [2:0] {IDLE, START, SHOW, SWAP, DONE} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [7:0] hold_eff;
  logic       last, tick, adv;
  assign hold_eff  = (hold == 8'd0) ? 8'd1 : hold;
  assign last      = frame_idx == 8'(NUM_FRAMES - 1);
  assign tick      = state == SHOW && frame_done && !pause;
  assign adv       = tick && cnt == 8'd1;
  assign busy      = state != IDLE;
  assign anim_done = state == DONE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = init ? START : IDLE;
      START: nxt = SHOW;
`ifdef GIF_LOOP_EN
      SHOW:  nxt = adv ? SWAP : SHOW;
`else
      SHOW:  nxt = adv ? (last ? DONE : SWAP) : SHOW;
`endif
      SWAP:  nxt = SHOW;
      DONE:  nxt = init ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Frame registers update on the transition edge so frame_base moves one cycle after the qualifying pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      panel_init <= 1'b0;
      frame_idx  <= '0;
      frame_base <= '0;
      cnt        <= '0;
    end else begin
      state      <= nxt;
      panel_init <= nxt inside {START, SHOW, SWAP};
      if (state == IDLE && nxt == START) begin
        frame_idx  <= '0;
        frame_base <= '0;
        cnt        <= hold_eff;
      end else if (nxt == SWAP) begin
        frame_idx  <= last ? 8'd0 : frame_idx + 8'd1;
        frame_base <= last ? '0 : frame_base + ADDR_W'(FRAME_WORDS);
        cnt        <= hold_eff;
      end else if (tick) begin
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule
